alarm_controller_nz: RTL and testbench

//  Parametrised anti-theft alarm core: N door zones, programmable per-zone entry delays, integrated seconds timer.

---
 rtl/alarm_controller_nz_pkg.sv | 40 ++++
 rtl/alarm_controller_nz_sec_timer.sv | 85 ++++++++
 rtl/alarm_controller_nz.sv | 219 +++++++++++++++++++++
 tb/tb_alarm_controller_nz.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_controller_nz_pkg.sv
// rtl/alarm_controller_nz_pkg.sv - shared encodings and index helpers for the alarm controller
//
// Contents:
//   ST_*        3-bit state codes shown on the display (ARMED=0 .. ARM_WAIT=5)
//   tmr_op_e    command from the FSM to the seconds timer
//   cnt_w       counter width for a modulus, never below 1 bit
//   idx_*       positions of the programmable times inside the parameter file
package alarm_controller_nz_pkg;

    localparam logic [2:0] ST_ARMED     = 3'd0;
    localparam logic [2:0] ST_TRIGGERED = 3'd1;
    localparam logic [2:0] ST_ACTIVATED = 3'd2;
    localparam logic [2:0] ST_DISARMED  = 3'd3;
    localparam logic [2:0] ST_DOOR_WAIT = 3'd4;
    localparam logic [2:0] ST_ARM_WAIT  = 3'd5;

    typedef enum logic [1:0] {
        TMR_HOLD  = 2'd0,
        TMR_LOAD  = 2'd1,
        TMR_CLEAR = 2'd2
    } tmr_op_e;

    // Width of a counter that must hold 0..n-1; a 1-cycle tick still needs one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int idx_arm();
        return 0;
    endfunction

    function automatic int idx_entry(input int zone);
        return zone + 1;
    endfunction

    function automatic int idx_alarm(input int n_zones);
        return n_zones + 1;
    endfunction

endpackage

// File: rtl/alarm_controller_nz_sec_timer.sv
// rtl/alarm_controller_nz_sec_timer.sv - prescaled seconds down-counter with load/clear and expiry
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   op_i         in   HOLD / LOAD (time=load_val, prescaler=0) / CLEAR (time=0, prescaler=0)
//   load_val_i   in   seconds to load
//   run_i        in   prescaler advances only while high
//   time_left_o  out  remaining seconds (registered, saturates at 0)
//   wrap_o       out  prescaler is at its last count this cycle (combinational)
//   expired_o    out  timer runs out this cycle (combinational, consumed by the FSM)
//   tick_o       out  registered one-cycle pulse per elapsed second of a running count
module alarm_controller_nz_sec_timer
    import alarm_controller_nz_pkg::*;
#(
    parameter int TIME_W = 4,
    parameter int CLK_HZ = 100_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  tmr_op_e           op_i,
    input  logic [TIME_W-1:0] load_val_i,
    input  logic              run_i,
    output logic [TIME_W-1:0] time_left_o,
    output logic              wrap_o,
    output logic              expired_o,
    output logic              tick_o
);

    localparam int            PW        = cnt_w(CLK_HZ);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    logic [PW-1:0]     presc_q, presc_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic              zero_load_q, zero_load_d;
    logic              tick_q, tick_d;

    assign wrap_o    = run_i && (presc_q == PRESC_MAX);
    // A zero-length load still has to produce one expiry, one cycle after the load.
    assign expired_o = (wrap_o && (time_q == TIME_W'(1))) || zero_load_q;

    always_comb begin
        presc_d     = presc_q;
        time_d      = time_q;
        zero_load_d = 1'b0;
        tick_d      = wrap_o && (time_q != '0);
        case (op_i)
            TMR_CLEAR: begin
                presc_d = '0;
                time_d  = '0;
            end
            TMR_LOAD: begin
                presc_d     = '0;
                time_d      = load_val_i;
                zero_load_d = (load_val_i == '0);
            end
            default: begin
                if (run_i) begin
                    presc_d = wrap_o ? '0 : presc_q + PW'(1);
                end
                if (wrap_o && (time_q != '0)) begin
                    time_d = time_q - TIME_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_q     <= '0;
            time_q      <= '0;
            zero_load_q <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            time_q      <= time_d;
            zero_load_q <= zero_load_d;
            tick_q      <= tick_d;
        end
    end

    assign time_left_o = time_q;
    assign tick_o      = tick_q;

endmodule

// File: rtl/alarm_controller_nz.sv
// rtl/alarm_controller_nz.sv - N-zone anti-theft alarm FSM with programmable delays and seconds timer
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   ignition   in   debounced ignition switch
//   zone_open  in   debounced door contacts, 1 = open; zone 0 is the driver door
//   reprogram  in   rising edge stores param_val at param_sel and forces ARMED
//   param_sel  in   0 arm time, 1..N_ZONES entry delays, N_ZONES+1 alarm time
//   param_val  in   seconds to store
//   status     out  LED: blinks (2 s period) in ARMED, on in TRIGGERED/ACTIVATED
//   siren_en   out  high in ACTIVATED
//   state      out  state code for the display
//   time_left  out  remaining seconds of the running timer
//   tick_1hz   out  pulse per elapsed timer second
module alarm_controller_nz
    import alarm_controller_nz_pkg::*;
#(
    parameter int N_ZONES    = 2,
    parameter int TIME_W     = 4,
    parameter int CLK_HZ     = 100_000_000,
    parameter int DEF_ARM    = 6,
    parameter int DEF_ENTRY0 = 8,
    parameter int DEF_ENTRY  = 15,
    parameter int DEF_ALARM  = 10
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           ignition,
    input  logic [N_ZONES-1:0]             zone_open,
    input  logic                           reprogram,
    input  logic [$clog2(N_ZONES+2)-1:0]   param_sel,
    input  logic [TIME_W-1:0]              param_val,
    output logic                           status,
    output logic                           siren_en,
    output logic [2:0]                     state,
    output logic [TIME_W-1:0]              time_left,
    output logic                           tick_1hz
);

    localparam int N_PARAMS = N_ZONES + 2;
    localparam int SEL_W    = $clog2(N_ZONES + 2);

    function automatic logic [TIME_W-1:0] def_val(input int idx);
        if (idx == idx_arm())          return TIME_W'(DEF_ARM);
        if (idx == idx_entry(0))       return TIME_W'(DEF_ENTRY0);
        if (idx == idx_alarm(N_ZONES)) return TIME_W'(DEF_ALARM);
        return TIME_W'(DEF_ENTRY);
    endfunction

    logic [2:0]        state_q, state_d;
    logic              zone0_q;
    logic              reprog_q;
    logic              status_q, status_d;
    logic              siren_q, siren_d;
    logic [TIME_W-1:0] param_q [N_PARAMS];

    logic              any_open;
    logic              zone0_rise, zone0_fall;
    logic              reprog_rise;
    logic [TIME_W-1:0] entry_val;
    tmr_op_e           tmr_op;
    logic [TIME_W-1:0] tmr_load_val;
    logic              tmr_run;
    logic              tmr_wrap;
    logic              tmr_expired;

    assign any_open    = |zone_open;
    assign zone0_rise  = zone_open[0] && !zone0_q;
    assign zone0_fall  = !zone_open[0] && zone0_q;
    assign reprog_rise = reprogram && !reprog_q;

    // The timer is frozen in DISARMED/DOOR_WAIT; in ARMED it runs with nothing loaded so the
    // prescaler keeps pacing the LED blink.
    assign tmr_run = (state_q == ST_ARMED) || (state_q == ST_TRIGGERED) ||
                     (state_q == ST_ACTIVATED) || (state_q == ST_ARM_WAIT);

    // Scan from the highest zone down so the lowest-index open zone's delay is the one kept.
    always_comb begin
        entry_val = param_q[idx_entry(0)];
        for (int z = N_ZONES - 1; z >= 0; z--) begin
            if (zone_open[z]) begin
                entry_val = param_q[idx_entry(z)];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        tmr_op       = TMR_HOLD;
        tmr_load_val = '0;
        if (reprog_rise) begin
            state_d = ST_ARMED;
            tmr_op  = TMR_CLEAR;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (any_open) begin
                        state_d      = ST_TRIGGERED;
                        tmr_op       = TMR_LOAD;
                        tmr_load_val = entry_val;
                    end
                end
                ST_TRIGGERED: begin
                    if (ignition) begin
                        state_d = ST_DISARMED;
                        tmr_op  = TMR_CLEAR;
                    end else if (tmr_expired) begin
                        state_d      = ST_ACTIVATED;
                        tmr_op       = TMR_LOAD;
                        tmr_load_val = param_q[idx_alarm(N_ZONES)];
                    end
                end
                ST_ACTIVATED: begin
                    if (ignition) begin
                        state_d = ST_DISARMED;
                        tmr_op  = TMR_CLEAR;
                    end else if (any_open) begin
                        // Keep the alarm period topped up while any door stays open.
                        tmr_op       = TMR_LOAD;
                        tmr_load_val = param_q[idx_alarm(N_ZONES)];
                    end else if (tmr_expired) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_DISARMED: begin
                    if (!ignition && zone0_rise) begin
                        state_d = ST_DOOR_WAIT;
                    end
                end
                ST_DOOR_WAIT: begin
                    if (ignition) begin
                        state_d = ST_DISARMED;
                        tmr_op  = TMR_CLEAR;
                    end else if (zone0_fall && !any_open) begin
                        state_d      = ST_ARM_WAIT;
                        tmr_op       = TMR_LOAD;
                        tmr_load_val = param_q[idx_arm()];
                    end
                end
                ST_ARM_WAIT: begin
                    if (ignition) begin
                        state_d = ST_DISARMED;
                        tmr_op  = TMR_CLEAR;
                    end else if (any_open) begin
                        state_d = ST_DOOR_WAIT;
                    end else if (tmr_expired) begin
                        state_d = ST_ARMED;
                    end
                end
                default: begin
                    state_d = ST_ARMED;
                    tmr_op  = TMR_CLEAR;
                end
            endcase
        end
    end

    // The blink phase restarts from dark on every entry to ARMED, including a reprogram.
    always_comb begin
        if (state_d == ST_ARMED) begin
            status_d = (state_q == ST_ARMED && !reprog_rise) ? (status_q ^ tmr_wrap) : 1'b0;
        end else begin
            status_d = (state_d == ST_TRIGGERED) || (state_d == ST_ACTIVATED);
        end
        siren_d = (state_d == ST_ACTIVATED);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_ARMED;
            zone0_q  <= 1'b0;
            reprog_q <= 1'b0;
            status_q <= 1'b0;
            siren_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            zone0_q  <= zone_open[0];
            reprog_q <= reprogram;
            status_q <= status_d;
            siren_q  <= siren_d;
        end
    end

    // Out-of-range indices match no entry and are dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_PARAMS; i++) begin
                param_q[i] <= def_val(i);
            end
        end else begin
            for (int i = 0; i < N_PARAMS; i++) begin
                if (reprog_rise && (param_sel == SEL_W'(i))) begin
                    param_q[i] <= param_val;
                end
            end
        end
    end

    alarm_controller_nz_sec_timer #(
        .TIME_W (TIME_W),
        .CLK_HZ (CLK_HZ)
    ) u_timer (
        .clock       (clock),
        .reset       (reset),
        .op_i        (tmr_op),
        .load_val_i  (tmr_load_val),
        .run_i       (tmr_run),
        .time_left_o (time_left),
        .wrap_o      (tmr_wrap),
        .expired_o   (tmr_expired),
        .tick_o      (tick_1hz)
    );

    assign state    = state_q;
    assign status   = status_q;
    assign siren_en = siren_q;

endmodule

// File: tb/tb_alarm_controller_nz.sv
// tb/tb_alarm_controller_nz.sv - self-checking bench for alarm_controller_nz against a cycle-count model
module tb_alarm_controller_nz;

    localparam int N   = 3;
    localparam int TW  = 4;
    localparam int CLK = 10;

    localparam int S_ARMED = 0, S_TRIG = 1, S_ACT = 2, S_DIS = 3, S_DOOR = 4, S_ARMW = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          ignition;
    logic [N-1:0]  zone_open;
    logic          reprogram;
    logic [2:0]    param_sel;
    logic [TW-1:0] param_val;
    logic          status;
    logic          siren_en;
    logic [2:0]    state;
    logic [TW-1:0] time_left;
    logic          tick_1hz;

    alarm_controller_nz #(
        .N_ZONES (N),
        .TIME_W  (TW),
        .CLK_HZ  (CLK)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ignition  (ignition),
        .zone_open (zone_open),
        .reprogram (reprogram),
        .param_sel (param_sel),
        .param_val (param_val),
        .status    (status),
        .siren_en  (siren_en),
        .state     (state),
        .time_left (time_left),
        .tick_1hz  (tick_1hz)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: a timer is a loaded length L plus the count of running cycles since the load;
    // seconds left = L - cycles/CLK, floored at 0.
    int m_st, m_L, m_cyc;
    bit m_zl, m_status, m_siren, m_tick, m_z0p, m_rpp;
    int m_par [0:N+1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int tl_of(input int L, input int cyc);
        int r;
        r = L - cyc / CLK;
        return (r > 0) ? r : 0;
    endfunction

    task automatic model_reset();
        m_st = S_ARMED; m_L = 0; m_cyc = 0; m_zl = 0;
        m_status = 0; m_siren = 0; m_tick = 0; m_z0p = 0; m_rpp = 0;
        m_par[0] = 6; m_par[1] = 8; m_par[2] = 15; m_par[3] = 15; m_par[4] = 10;
    endtask

    task automatic step();
        int  ns, lv, tl;
        bit  running, wrap, expired, rpr, z0r, z0f, any, clr, ld, found;
        running = (m_st == S_ARMED) || (m_st == S_TRIG) || (m_st == S_ACT) || (m_st == S_ARMW);
        wrap    = running && (((m_cyc + 1) % CLK) == 0);
        tl      = tl_of(m_L, m_cyc);
        expired = (wrap && tl == 1) || m_zl;
        rpr     = reprogram && !m_rpp;
        z0r     = zone_open[0] && !m_z0p;
        z0f     = !zone_open[0] && m_z0p;
        any     = (zone_open != '0);
        ns = m_st; clr = 0; ld = 0; lv = 0;
        if (rpr) begin
            if (int'(param_sel) <= N + 1) m_par[int'(param_sel)] = int'(param_val);
            ns = S_ARMED; clr = 1;
        end else begin
            case (m_st)
                S_ARMED: if (any) begin
                    found = 0;
                    for (int z = 0; z < N; z++) begin
                        if (zone_open[z] && !found) begin lv = m_par[1 + z]; found = 1; end
                    end
                    ns = S_TRIG; ld = 1;
                end
                S_TRIG: begin
                    if (ignition) begin ns = S_DIS; clr = 1; end
                    else if (expired) begin ns = S_ACT; ld = 1; lv = m_par[N + 1]; end
                end
                S_ACT: begin
                    if (ignition) begin ns = S_DIS; clr = 1; end
                    else if (any) begin ld = 1; lv = m_par[N + 1]; end
                    else if (expired) ns = S_ARMED;
                end
                S_DIS: if (!ignition && z0r) ns = S_DOOR;
                S_DOOR: begin
                    if (ignition) begin ns = S_DIS; clr = 1; end
                    else if (z0f && !any) begin ns = S_ARMW; ld = 1; lv = m_par[0]; end
                end
                default: begin
                    if (ignition) begin ns = S_DIS; clr = 1; end
                    else if (any) ns = S_DOOR;
                    else if (expired) ns = S_ARMED;
                end
            endcase
        end
        m_tick   = wrap && (tl != 0);
        m_status = (ns == S_ARMED) ? ((m_st == S_ARMED && !rpr) ? (m_status ^ wrap) : 1'b0)
                                   : (ns == S_TRIG || ns == S_ACT);
        m_siren  = (ns == S_ACT);
        if (clr) begin m_L = 0; m_cyc = 0; m_zl = 0; end
        else if (ld) begin m_L = lv; m_cyc = 0; m_zl = (lv == 0); end
        else begin m_zl = 0; if (running) m_cyc++; end
        m_z0p = zone_open[0];
        m_rpp = reprogram;
        m_st  = ns;
        @(posedge clock);
        #1;
        chk("state", state, m_st);
        chk("siren_en", siren_en, m_siren);
        chk("status", status, m_status);
        chk("time_left", time_left, tl_of(m_L, m_cyc));
        chk("tick_1hz", tick_1hz, m_tick);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int r, zi;
        reset = 1'b0; ignition = 1'b0; zone_open = '0; reprogram = 1'b0;
        param_sel = '0; param_val = '0;
        model_reset();
        #12;
        chk("rst_state", state, S_ARMED);
        chk("rst_time", time_left, 0);
        chk("rst_siren", siren_en, 0);
        chk("rst_status", status, 0);
        chk("rst_tick", tick_1hz, 0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Free-running blink in ARMED, then zone 2 triggers and the alarm times out.
        steps(25);
        zone_open = 3'b100; step();
        chk("z2_trig_state", state, S_TRIG);
        chk("z2_entry", time_left, 15);
        zone_open = '0;
        steps(149);
        chk("trig_before_exp", state, S_TRIG);
        step();
        chk("act_state", state, S_ACT);
        chk("act_siren", siren_en, 1);
        chk("act_time", time_left, 10);
        steps(100);
        chk("act_to_armed", state, S_ARMED);

        // Zones 1 and 2 together, ignition disarms, reprogram out of range just re-arms.
        zone_open = 3'b110; step();
        chk("z12_entry", time_left, 15);
        zone_open = '0; ignition = 1'b1; step();
        chk("ign_disarm", state, S_DIS);
        ignition = 1'b0;
        reprogram = 1'b1; param_sel = 3'd7; param_val = 4'd1; step();
        chk("rp_oor_armed", state, S_ARMED);
        reprogram = 1'b0;
        zone_open = 3'b001; step();
        chk("z0_entry", time_left, 8);
        zone_open = '0;
        steps(79);
        ignition = 1'b1; step();
        chk("ign_on_expiry", state, S_DIS);
        chk("ign_on_expiry_siren", siren_en, 0);
        ignition = 1'b0;

        // Driver door re-arm sequence with a reopen part-way through.
        zone_open = 3'b001; step();
        chk("door_wait", state, S_DOOR);
        zone_open = '0; step();
        chk("arm_wait", state, S_ARMW);
        chk("arm_wait_time", time_left, 6);
        steps(30);
        chk("arm_wait_3s", time_left, 3);
        zone_open = 3'b001; step();
        chk("reopen_door_wait", state, S_DOOR);
        steps(5);
        chk("door_wait_frozen", time_left, 3);
        zone_open = '0; step();
        chk("rearm_reload", time_left, 6);
        steps(59);
        chk("arm_wait_hold", state, S_ARMW);
        step();
        chk("arm_wait_done", state, S_ARMED);

        // Reprogram the alarm time to 0 while ACTIVATED.
        zone_open = 3'b100; step();
        zone_open = '0;
        steps(150);
        chk("act2_state", state, S_ACT);
        reprogram = 1'b1; param_sel = 3'd4; param_val = 4'd0; step();
        chk("rp_act_state", state, S_ARMED);
        chk("rp_act_siren", siren_en, 0);
        chk("rp_act_time", time_left, 0);
        reprogram = 1'b0;
        zone_open = 3'b010; step();
        steps(150);
        chk("act0_state", state, S_ACT);
        steps(5);
        chk("act0_hold", state, S_ACT);
        zone_open = '0; step();
        chk("act0_expire", state, S_ARMED);

        // Asynchronous reset in the middle of ARM_WAIT.
        zone_open = 3'b001; step();
        zone_open = '0; ignition = 1'b1; step();
        ignition = 1'b0;
        zone_open = 3'b001; step();
        zone_open = '0; step();
        steps(20);
        chk("pre_reset_arm_wait", state, S_ARMW);
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("async_rst_state", state, S_ARMED);
        chk("async_rst_time", time_left, 0);
        chk("async_rst_status", status, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        zone_open = 3'b010; step();
        chk("post_rst_entry", time_left, 15);
        zone_open = '0;
        steps(150);
        chk("post_rst_alarm", time_left, 10);

        // Randomised traffic, short programmed times so every path cycles often.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (reprogram) reprogram = 1'b0;
            if (ignition) begin
                if (r < 6) ignition = 1'b0;
            end else if (r < 2) begin
                ignition = 1'b1;
            end
            if (r >= 10 && r < 20) begin
                zi = int'($urandom_range(0, N - 1));
                zone_open[zi] = ~zone_open[zi];
            end else if (r >= 20 && r < 23) begin
                reprogram = 1'b1;
                param_sel = 3'($urandom_range(0, 7));
                param_val = 4'($urandom_range(0, 4));
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
